debug_bus_master: RTL and testbench
===================================

// Module: debug_bus_master
// PURPOSE
//  Host-side initiator for the core's debug cache ports (InstCache/DataCache A2/WD2/WE2/RD2).
//  Parses a byte-serial command stream (e.g. from a UART receiver) into single-word debug
//  reads and writes, and returns byte-serial responses.
//  Also owns core_hold, which holds the core in reset while a program is loaded.
// PARAMETERS
//  READ_LATENCY  1      cycles from A2 stable to RD2 valid (>=1)
//  ACK_BYTE      8'hA5  response byte for a completed write / RUN / HALT
//  ERR_BYTE      8'hEE  response byte for an unknown opcode
// PORTS
//  CPU_CLK                   in   1   clock
//  CPU_RST                   in   1   asynchronous, active-low reset
//  cmd_valid                 in   1   command byte valid
//  cmd_data                  in   8   command byte
//  cmd_ready                 out  1   block accepts cmd_data this cycle
//  rsp_valid                 out  1   response byte valid
//  rsp_data                  out  8   response byte
//  rsp_ready                 in   1   sink accepts rsp_data this cycle
//  Debug_InstCache_A2        out  32  inst cache debug address
//  Debug_InstCache_WD2       out  32  inst cache debug write data
//  Debug_InstCache_WE2       out  4   inst cache debug byte write enables
//  Debug_InstCache_RD2       in   32  inst cache debug read data
//  Debug_DataCache_A2/WD2/WE2/RD2     same set of four ports for the data cache
//  core_hold                 out  1   1 = hold the core in reset
// BEHAVIOUR
//  Reset (CPU_RST=0, any time, asynchronous):
//   - state=IDLE; all A2/WD2/WE2=0; cmd_ready=0; rsp_valid=0; rsp_data=0; core_hold=1.
//   - Reset mid-command discards the partial command; no WE2 pulse is issued.
//  Byte handshake: a byte moves on cmd_valid&&cmd_ready (rsp_valid&&rsp_ready).
//   - rsp_valid/rsp_data stay stable until accepted.
//  Opcodes: 01 WR_INST, 02 WR_DATA, 03 RD_INST, 04 RD_DATA, 05 RUN, 06 HALT.
//   - Frame = opcode, then ADDR[7:0..31:24] for 01-04, then DATA[7:0..31:24] for 01/02.
//   - All fields are little-endian.
//  FSM: IDLE -> ADDR(4 bytes) -> [DATA(4 bytes)] -> ACCESS -> [WAIT] -> RESP -> IDLE.
//   - cmd_ready=1 only in IDLE/ADDR/DATA.
//   - A byte counter (0..3) wraps to 0 on each field change.
//  ACCESS: A2 = {addr[31:2],2'b00}. Unaligned low bits are dropped silently.
//   - Write: WD2=data and WE2=4'hF for exactly one cycle, on the selected cache only.
//   - The other cache sees WE2=0 throughout.
//  Read: A2 held through ACCESS + READ_LATENCY WAIT cycles; RD2 is sampled on the last cycle.
//   - RESP then sends 4 bytes, LSB first.
//  Writes, RUN, HALT: RESP sends one ACK_BYTE.
//   - RUN clears core_hold; HALT sets it.
//   - core_hold changes in the cycle ACK becomes valid.
//  Unknown opcode: no address/data bytes are consumed; RESP sends one ERR_BYTE.
//  A2 returns to 0 in IDLE. WE2 is 0 in every state except the ACCESS cycle of a write.
//  rsp_ready held low: the FSM stalls in RESP indefinitely with no change to the cache ports.
//  Throughput: one command in flight; a new opcode is accepted the cycle after the last RESP byte.
// TESTING
//  - Reset release:
//    - core_hold=1, WE2=0, rsp_valid=0.
//    - Assert CPU_RST low mid-ADDR: state returns to IDLE and no WE2 pulse appears.
//  - WR_INST 01,00 00 00 00,13 05 10 00:
//    - Inst WE2=F for exactly 1 cycle, A2=0, WD2=32'h00100513.
//    - Data WE2 stays 0; response A5.
//  - RD_DATA 04,08 00 00 00 with RD2=32'hDEADBEEF:
//    - Data A2=8 held for 1+READ_LATENCY cycles.
//    - Response EF BE AD DE, with rsp_ready toggled 1/0 each cycle; bytes must not repeat or drop.
//  - Unaligned WR_DATA 02,07 00 00 00,...: A2=4. Unknown opcode 7F: response EE only.
//  - Sequence HALT (06), then RUN (05):
//    - Responses A5, A5.
//    - core_hold 1->0, changing in the cycle the RUN ACK becomes valid.
//  - Back-to-back commands with cmd_valid held high: cmd_ready=0 during ACCESS/WAIT/RESP; no byte lost.

Source files
------------

// File: rtl/debug_bus_master_if.sv
// Host-side debug bus bundle: byte command/response streams plus both debug cache ports and core_hold.
// master = the debug bus master block, slave = the host/caches around it.
interface debug_bus_master_if;
  logic        cmd_valid;
  logic [7:0]  cmd_data;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_ready;
  logic [31:0] Debug_InstCache_A2;
  logic [31:0] Debug_InstCache_WD2;
  logic [3:0]  Debug_InstCache_WE2;
  logic [31:0] Debug_InstCache_RD2;
  logic [31:0] Debug_DataCache_A2;
  logic [31:0] Debug_DataCache_WD2;
  logic [3:0]  Debug_DataCache_WE2;
  logic [31:0] Debug_DataCache_RD2;
  logic        core_hold;

  modport master (
    input  cmd_valid, cmd_data, rsp_ready, Debug_InstCache_RD2, Debug_DataCache_RD2,
    output cmd_ready, rsp_valid, rsp_data,
    output Debug_InstCache_A2, Debug_InstCache_WD2, Debug_InstCache_WE2,
    output Debug_DataCache_A2, Debug_DataCache_WD2, Debug_DataCache_WE2,
    output core_hold
  );

  modport slave (
    output cmd_valid, cmd_data, rsp_ready, Debug_InstCache_RD2, Debug_DataCache_RD2,
    input  cmd_ready, rsp_valid, rsp_data,
    input  Debug_InstCache_A2, Debug_InstCache_WD2, Debug_InstCache_WE2,
    input  Debug_DataCache_A2, Debug_DataCache_WD2, Debug_DataCache_WE2,
    input  core_hold
  );
endinterface

// File: rtl/debug_bus_master.sv
// Byte-serial command parser driving single-word reads/writes on the inst/data debug cache ports.
// Also owns core_hold, which keeps the core in reset while a program is loaded.
module debug_bus_master #(
  parameter int         READ_LATENCY = 1,
  parameter logic [7:0] ACK_BYTE     = 8'hA5,
  parameter logic [7:0] ERR_BYTE     = 8'hEE
) (
  input logic                CPU_CLK,
  input logic                CPU_RST,
  debug_bus_master_if.master bus
);
  localparam logic [7:0] OP_WR_INST = 8'h01;
  localparam logic [7:0] OP_WR_DATA = 8'h02;
  localparam logic [7:0] OP_RD_INST = 8'h03;
  localparam logic [7:0] OP_RD_DATA = 8'h04;
  localparam logic [7:0] OP_RUN     = 8'h05;
  localparam logic [7:0] OP_HALT    = 8'h06;

  localparam int             WCW       = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(READ_LATENCY - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ACCESS, S_WAIT, S_RESP} state_e;

  state_e         state_q, state_d;
  logic [7:0]     opcode_q;
  logic [31:0]    addr_q, data_q, rd_data_q;
  logic [1:0]     byte_cnt_q, rsp_cnt_q;
  logic [WCW-1:0] wait_cnt_q;
  logic           core_hold_q;

  logic        cmd_fire, rsp_fire;
  logic        op_write, op_read, op_inst, op_data, op_known, rsp_last, in_access;
  logic [31:0] word_addr;

  assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
  assign rsp_fire  = bus.rsp_valid && bus.rsp_ready;
  assign op_write  = (opcode_q == OP_WR_INST) || (opcode_q == OP_WR_DATA);
  assign op_read   = (opcode_q == OP_RD_INST) || (opcode_q == OP_RD_DATA);
  assign op_inst   = (opcode_q == OP_WR_INST) || (opcode_q == OP_RD_INST);
  assign op_data   = (opcode_q == OP_WR_DATA) || (opcode_q == OP_RD_DATA);
  assign op_known  = (opcode_q >= OP_WR_INST) && (opcode_q <= OP_HALT);
  assign rsp_last  = op_read ? (rsp_cnt_q == 2'd3) : 1'b1;
  assign in_access = (state_q == S_ACCESS) || (state_q == S_WAIT);
  // Word-aligned access: the low address bits are dropped without complaint.
  assign word_addr = addr_q & 32'hFFFF_FFFC;
  assign bus.core_hold = core_hold_q;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
  always_comb begin
    state_d                 = state_q;
    bus.cmd_ready           = 1'b0;
    bus.rsp_valid           = 1'b0;
    bus.rsp_data            = 8'h00;
    bus.Debug_InstCache_A2  = 32'h0;
    bus.Debug_InstCache_WD2 = 32'h0;
    bus.Debug_InstCache_WE2 = 4'h0;
    bus.Debug_DataCache_A2  = 32'h0;
    bus.Debug_DataCache_WD2 = 32'h0;
    bus.Debug_DataCache_WE2 = 4'h0;

    unique case (state_q)
      S_IDLE: begin
        bus.cmd_ready = CPU_RST;
        if (cmd_fire)
          state_d = (cmd_data_has_addr(bus.cmd_data)) ? S_ADDR : S_ACCESS;
      end
      S_ADDR: begin
        bus.cmd_ready = CPU_RST;
        if (cmd_fire && byte_cnt_q == 2'd3) state_d = op_write ? S_DATA : S_ACCESS;
      end
      S_DATA: begin
        bus.cmd_ready = CPU_RST;
        if (cmd_fire && byte_cnt_q == 2'd3) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = op_read ? S_WAIT : S_RESP;
      S_WAIT:   if (wait_cnt_q == WAIT_LAST) state_d = S_RESP;
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (op_read)       bus.rsp_data = rd_data_q[8*rsp_cnt_q +: 8];
        else if (op_known) bus.rsp_data = ACK_BYTE;
        else               bus.rsp_data = ERR_BYTE;
        if (rsp_fire && rsp_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (in_access && op_inst) bus.Debug_InstCache_A2 = word_addr;
    if (in_access && op_data) bus.Debug_DataCache_A2 = word_addr;
    if (state_q == S_ACCESS && opcode_q == OP_WR_INST) begin
      bus.Debug_InstCache_WD2 = data_q;
      bus.Debug_InstCache_WE2 = 4'hF;
    end
    if (state_q == S_ACCESS && opcode_q == OP_WR_DATA) begin
      bus.Debug_DataCache_WD2 = data_q;
      bus.Debug_DataCache_WE2 = 4'hF;
    end
  end

  function automatic logic cmd_data_has_addr(input logic [7:0] op);
    return (op >= OP_WR_INST) && (op <= OP_RD_DATA);
  endfunction

  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) begin
      opcode_q    <= 8'h00;
      addr_q      <= 32'h0;
      data_q      <= 32'h0;
      rd_data_q   <= 32'h0;
      byte_cnt_q  <= 2'd0;
      rsp_cnt_q   <= 2'd0;
      wait_cnt_q  <= '0;
      core_hold_q <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: if (cmd_fire) begin
          opcode_q   <= bus.cmd_data;
          byte_cnt_q <= 2'd0;
        end
        // The 2-bit byte counter wraps to 0 after byte 3, ready for the next field.
        S_ADDR: if (cmd_fire) begin
          addr_q[8*byte_cnt_q +: 8] <= bus.cmd_data;
          byte_cnt_q                <= byte_cnt_q + 2'd1;
        end
        S_DATA: if (cmd_fire) begin
          data_q[8*byte_cnt_q +: 8] <= bus.cmd_data;
          byte_cnt_q                <= byte_cnt_q + 2'd1;
        end
        S_ACCESS: begin
          wait_cnt_q <= '0;
          rsp_cnt_q  <= 2'd0;
          if (opcode_q == OP_RUN)  core_hold_q <= 1'b0;
          if (opcode_q == OP_HALT) core_hold_q <= 1'b1;
        end
        S_WAIT: begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
          if (wait_cnt_q == WAIT_LAST)
            rd_data_q <= op_inst ? bus.Debug_InstCache_RD2 : bus.Debug_DataCache_RD2;
        end
        S_RESP: if (rsp_fire) rsp_cnt_q <= rsp_cnt_q + 2'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_bus_master.sv
// Self-checking bench for debug_bus_master: directed corner cases, a vector table,
// back-to-back streaming and randomized commands against a word-level reference model.
module tb_debug_bus_master;
  localparam int         RL  = 1;
  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] ERR = 8'hEE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_bus_master_if bus();

  debug_bus_master #(.READ_LATENCY(RL), .ACK_BYTE(ACK), .ERR_BYTE(ERR)) dut (
    .CPU_CLK(clk),
    .CPU_RST(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- cache-side slave memories (bus-level behaviour) ----------------
  logic [31:0] inst_mem [logic [31:0]];
  logic [31:0] data_mem [logic [31:0]];
  logic [31:0] data_preload [logic [31:0]];

  function automatic logic [31:0] rd_inst(input logic [31:0] a);
    return inst_mem.exists(a) ? inst_mem[a] : 32'h0;
  endfunction
  function automatic logic [31:0] rd_data(input logic [31:0] a);
    if (data_mem.exists(a)) return data_mem[a];
    return data_preload.exists(a) ? data_preload[a] : 32'h0;
  endfunction

  // RD2 follows A2 after one clock, matching READ_LATENCY = 1.
  always @(posedge clk) begin
    bus.Debug_InstCache_RD2 <= rd_inst(bus.Debug_InstCache_A2);
    bus.Debug_DataCache_RD2 <= rd_data(bus.Debug_DataCache_A2);
    if (bus.Debug_InstCache_WE2 != 4'h0) inst_mem[bus.Debug_InstCache_A2] = bus.Debug_InstCache_WD2;
    if (bus.Debug_DataCache_WE2 != 4'h0) data_mem[bus.Debug_DataCache_A2] = bus.Debug_DataCache_WD2;
  end

  // ---------------- port monitor (cumulative counters, sampled mid-cycle) ----------------
  int          inst_we_cyc = 0, data_we_cyc = 0, data_a2_cyc = 0, busy_viol = 0;
  logic [31:0] inst_we_a2, inst_we_wd2, data_we_a2, data_we_wd2, data_a2_last;
  logic [3:0]  inst_we_val;

  always @(negedge clk) begin
    if (bus.Debug_InstCache_WE2 != 4'h0) begin
      inst_we_cyc++;
      inst_we_a2  = bus.Debug_InstCache_A2;
      inst_we_wd2 = bus.Debug_InstCache_WD2;
      inst_we_val = bus.Debug_InstCache_WE2;
    end
    if (bus.Debug_DataCache_WE2 != 4'h0) begin
      data_we_cyc++;
      data_we_a2  = bus.Debug_DataCache_A2;
      data_we_wd2 = bus.Debug_DataCache_WD2;
    end
    if (bus.Debug_DataCache_A2 != 32'h0) begin
      data_a2_cyc++;
      data_a2_last = bus.Debug_DataCache_A2;
    end
    if (bus.cmd_ready && (bus.rsp_valid || bus.Debug_InstCache_A2 != 0 || bus.Debug_DataCache_A2 != 0 ||
                          bus.Debug_InstCache_WE2 != 0 || bus.Debug_DataCache_WE2 != 0))
      busy_viol++;
  end

  // ---------------- reference model: word-level memories and hold flag ----------------
  logic [31:0] ref_inst [logic [31:0]];
  logic [31:0] ref_data [logic [31:0]];
  logic        exp_hold = 1'b1;

  task automatic model(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] w, output int n);
    logic [31:0] a;
    a = addr - (addr % 4);
    n = 1;
    w = {24'h0, ACK};
    case (op)
      8'h01: ref_inst[a] = data;
      8'h02: ref_data[a] = data;
      8'h03: begin n = 4; w = ref_inst.exists(a) ? ref_inst[a] : 32'h0; end
      8'h04: begin n = 4; w = ref_data.exists(a) ? ref_data[a] : 32'h0; end
      8'h05: exp_hold = 1'b0;
      8'h06: exp_hold = 1'b1;
      default: w = {24'h0, ERR};
    endcase
  endtask

  // ---------------- byte-level drivers (entered and left at posedge + 1) ----------------
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = b;
    do begin @(negedge clk); n++; end while (!bus.cmd_ready && n < 200);
    if (!bus.cmd_ready) check("cmd_ready_timeout", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b, input int stall);
    int n = 0;
    repeat (stall) @(posedge clk);
    if (stall > 0) #1;
    bus.rsp_ready = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 200);
    if (!bus.rsp_valid) check("rsp_valid_timeout", bus.rsp_valid, 1'b1);
    b = bus.rsp_data;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
    send_byte(op);
    if (op inside {8'h01, 8'h02, 8'h03, 8'h04}) for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    if (op inside {8'h01, 8'h02}) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
  endtask

  task automatic do_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input int stall_max, output logic [31:0] got, output logic [31:0] exp);
    int n;
    logic [7:0] b;
    model(op, addr, data, exp, n);
    send_frame(op, addr, data);
    got = 32'h0;
    for (int i = 0; i < n; i++) begin
      recv_byte(b, int'($urandom_range(stall_max, 0)));
      got[8*i +: 8] = b;
    end
  endtask

  // ---------------- back-to-back stream helpers ----------------
  logic [7:0] stream_q[$];
  logic [7:0] exp_rsp_q[$];
  logic [7:0] got_rsp_q[$];
  int         drv_idx;

  task automatic add_stream(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] w;
    int n;
    model(op, addr, data, w, n);
    stream_q.push_back(op);
    if (op inside {8'h01, 8'h02, 8'h03, 8'h04}) for (int i = 0; i < 4; i++) stream_q.push_back(addr[8*i +: 8]);
    if (op inside {8'h01, 8'h02}) for (int i = 0; i < 4; i++) stream_q.push_back(data[8*i +: 8]);
    for (int i = 0; i < n; i++) exp_rsp_q.push_back(w[8*i +: 8]);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rsp;
    logic        exp_hold;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[12];
    logic [31:0] got, exp;
    logic [7:0]  b;
    logic        hold_before;
    int          n, snap_i, snap_d, snap_a;

    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    bus.rsp_ready = 1'b0;

    // ---- reset state ----
    #12;
    check("rst_core_hold", bus.core_hold, 1'b1);
    check("rst_inst_we", bus.Debug_InstCache_WE2, 4'h0);
    check("rst_data_we", bus.Debug_DataCache_WE2, 4'h0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_data", bus.rsp_data, 8'h00);
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    check("rst_inst_a2", bus.Debug_InstCache_A2, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", bus.cmd_ready, 1'b1);
    check("idle_core_hold", bus.core_hold, 1'b1);
    @(posedge clk); #1;

    // ---- WR_INST 01, 00000000, 00100513 ----
    snap_i = inst_we_cyc; snap_d = data_we_cyc;
    do_cmd(8'h01, 32'h0, 32'h0010_0513, 0, got, exp);
    check("wr_inst_rsp", got, 32'hA5);
    check("wr_inst_we_cycles", inst_we_cyc - snap_i, 1);
    check("wr_inst_a2", inst_we_a2, 32'h0);
    check("wr_inst_wd2", inst_we_wd2, 32'h0010_0513);
    check("wr_inst_we_val", inst_we_val, 4'hF);
    check("wr_inst_data_we_quiet", data_we_cyc - snap_d, 0);

    // ---- RD_DATA 04, 08 with RD2 = DEADBEEF and rsp_ready toggling ----
    data_preload[32'h8] = 32'hDEAD_BEEF;
    ref_data[32'h8]     = 32'hDEAD_BEEF;
    snap_a = data_a2_cyc;
    model(8'h04, 32'h8, 32'h0, exp, n);
    send_frame(8'h04, 32'h8, 32'h0);
    got_rsp_q.delete();
    n = 0;
    bus.rsp_ready = 1'b1;
    while (got_rsp_q.size() < 4 && n < 60) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) got_rsp_q.push_back(bus.rsp_data);
      @(posedge clk); #1;
      bus.rsp_ready = ~bus.rsp_ready;
      n++;
    end
    bus.rsp_ready = 1'b0;
    check("rd_toggle_count", got_rsp_q.size(), 4);
    for (int i = 0; i < 4 && i < got_rsp_q.size(); i++)
      check($sformatf("rd_toggle_byte%0d", i), got_rsp_q[i], exp[8*i +: 8]);
    check("rd_model_word", exp, 32'hDEAD_BEEF);
    check("rd_a2_value", data_a2_last, 32'h8);
    check("rd_a2_cycles", data_a2_cyc - snap_a, 1 + RL);
    @(negedge clk);
    check("rd_no_extra_byte", bus.rsp_valid, 1'b0);
    @(posedge clk); #1;

    // ---- HALT then RUN: core_hold drops in the cycle RUN's ACK becomes valid ----
    do_cmd(8'h06, 32'h0, 32'h0, 1, got, exp);
    check("halt_rsp", got, 32'hA5);
    check("halt_hold", bus.core_hold, 1'b1);
    model(8'h05, 32'h0, 32'h0, exp, n);
    send_byte(8'h05);
    hold_before = 1'bx;
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 20) begin
      hold_before = bus.core_hold;
      @(negedge clk);
      n++;
    end
    check("run_hold_before_ack", hold_before, 1'b1);
    check("run_hold_at_ack", bus.core_hold, 1'b0);
    check("run_ack_byte", bus.rsp_data, ACK);
    @(posedge clk); #1;
    recv_byte(b, 0);
    check("run_rsp", b, ACK);
    check("run_hold_after", bus.core_hold, exp_hold);

    // ---- reset asserted mid-ADDR of a WR_INST ----
    snap_i = inst_we_cyc; snap_d = data_we_cyc;
    send_byte(8'h01);
    send_byte(8'h44);
    send_byte(8'h00);
    #3 rst_n = 1'b0;
    exp_hold = 1'b1;
    #1;
    check("midrst_cmd_ready", bus.cmd_ready, 1'b0);
    check("midrst_core_hold", bus.core_hold, 1'b1);
    check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_inst_we", inst_we_cyc - snap_i, 0);
    check("midrst_no_data_we", data_we_cyc - snap_d, 0);
    do_cmd(8'h06, 32'h0, 32'h0, 0, got, exp);
    check("midrst_fresh_cmd_rsp", got, 32'hA5);

    // ---- vector table ----
    vecs[0]  = '{8'h01, 32'h20, 32'h1122_3344, 32'hA5,        1'b1};
    vecs[1]  = '{8'h03, 32'h20, 32'h0,         32'h1122_3344, 1'b1};
    vecs[2]  = '{8'h03, 32'h00, 32'h0,         32'h0010_0513, 1'b1};
    vecs[3]  = '{8'h02, 32'h07, 32'h0BAD_F00D, 32'hA5,        1'b1};
    vecs[4]  = '{8'h04, 32'h04, 32'h0,         32'h0BAD_F00D, 1'b1};
    vecs[5]  = '{8'h04, 32'h06, 32'h0,         32'h0BAD_F00D, 1'b1};
    vecs[6]  = '{8'h03, 32'h04, 32'h0,         32'h0,         1'b1};
    vecs[7]  = '{8'h7F, 32'h0,  32'h0,         32'hEE,        1'b1};
    vecs[8]  = '{8'h05, 32'h0,  32'h0,         32'hA5,        1'b0};
    vecs[9]  = '{8'h00, 32'h0,  32'h0,         32'hEE,        1'b0};
    vecs[10] = '{8'h06, 32'h0,  32'h0,         32'hA5,        1'b1};
    vecs[11] = '{8'h04, 32'h08, 32'h0,         32'hDEAD_BEEF, 1'b1};
    for (int i = 0; i < 12; i++) begin
      snap_i = inst_we_cyc; snap_d = data_we_cyc;
      do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, 2, got, exp);
      check($sformatf("vec%0d_rsp", i), got, vecs[i].exp_rsp);
      check($sformatf("vec%0d_hold", i), bus.core_hold, vecs[i].exp_hold);
      if (vecs[i].op == 8'h01) begin
        check($sformatf("vec%0d_inst_a2", i), inst_we_a2, vecs[i].addr - (vecs[i].addr % 4));
        check($sformatf("vec%0d_inst_wd2", i), inst_we_wd2, vecs[i].data);
      end
      if (vecs[i].op == 8'h02) begin
        check($sformatf("vec%0d_data_a2", i), data_we_a2, vecs[i].addr - (vecs[i].addr % 4));
        check($sformatf("vec%0d_data_wd2", i), data_we_wd2, vecs[i].data);
      end
      check($sformatf("vec%0d_inst_we_cycles", i), inst_we_cyc - snap_i, (vecs[i].op == 8'h01) ? 1 : 0);
      check($sformatf("vec%0d_data_we_cycles", i), data_we_cyc - snap_d, (vecs[i].op == 8'h02) ? 1 : 0);
      @(negedge clk);
      check($sformatf("vec%0d_idle_after", i), bus.rsp_valid, 1'b0);
      @(posedge clk); #1;
    end

    // ---- back-to-back commands with cmd_valid held high ----
    add_stream(8'h01, 32'h10, 32'hCAFE_F00D);
    add_stream(8'h03, 32'h10, 32'h0);
    add_stream(8'h06, 32'h0,  32'h0);
    add_stream(8'h7F, 32'h0,  32'h0);
    add_stream(8'h04, 32'h08, 32'h0);
    add_stream(8'h02, 32'h0C, 32'h55AA_55AA);
    add_stream(8'h04, 32'h0C, 32'h0);
    got_rsp_q.delete();
    bus.rsp_ready = 1'b1;
    fork
      begin
        automatic int  idx = 0;
        automatic int  cyc = 0;
        automatic logic fire;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = stream_q[0];
        while (idx < stream_q.size() && cyc < 2000) begin
          @(negedge clk);
          fire = bus.cmd_ready;
          @(posedge clk); #1;
          cyc++;
          if (fire) begin
            idx++;
            if (idx < stream_q.size()) bus.cmd_data = stream_q[idx];
          end
        end
        bus.cmd_valid = 1'b0;
        drv_idx = idx;
      end
      begin
        automatic int cyc = 0;
        while (got_rsp_q.size() < exp_rsp_q.size() && cyc < 2000) begin
          @(negedge clk);
          if (bus.rsp_valid) got_rsp_q.push_back(bus.rsp_data);
          cyc++;
        end
      end
    join
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("b2b_cmd_bytes", drv_idx, stream_q.size());
    check("b2b_rsp_count", got_rsp_q.size(), exp_rsp_q.size());
    for (int i = 0; i < exp_rsp_q.size() && i < got_rsp_q.size(); i++)
      check($sformatf("b2b_rsp_byte%0d", i), got_rsp_q[i], exp_rsp_q[i]);

    // ---- randomized commands against the reference model ----
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  op;
      logic [31:0] addr, data;
      int          r;
      r    = int'($urandom_range(9, 0));
      addr = 32'($urandom_range(31, 0));
      data = $urandom;
      case (r)
        0, 1:    op = 8'h01;
        2, 3:    op = 8'h02;
        4, 5:    op = 8'h03;
        6, 7:    op = 8'h04;
        8:       op = ($urandom_range(1, 0) == 1) ? 8'h05 : 8'h06;
        default: op = 8'($urandom_range(255, 7));
      endcase
      do_cmd(op, addr, data, 3, got, exp);
      check($sformatf("rand%0d_op%02h_rsp", i, op), got, exp);
      check($sformatf("rand%0d_hold", i), bus.core_hold, exp_hold);
    end

    check("cmd_ready_while_busy_cycles", busy_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
